// File: rtl/countbits_pkg.sv
// Shared types and the clamped adder for the countbits frame accumulator.
package countbits_pkg;

  localparam int CB_ACC_W = 16;
  localparam int CB_MAX_W = 32;

  typedef enum logic {ACCUM, HOLD} cb_state_t;

  typedef struct packed {
    logic [CB_MAX_W-1:0] val;
    logic                carry;
  } sat_res_t;

  // Add clamped to 2^w-1; carry flags that the clamp kicked in.
  function automatic sat_res_t sat_add(input logic [CB_MAX_W-1:0] a,
                                       input logic [CB_MAX_W-1:0] b,
                                       input int unsigned         w);
    logic [CB_MAX_W:0] sum, lim;
    sat_res_t r;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{CB_MAX_W{1'b0}}, 1'b1} << w) - {{CB_MAX_W{1'b0}}, 1'b1};
    r.carry = (sum > lim);
    r.val   = r.carry ? lim[CB_MAX_W-1:0] : sum[CB_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/countbits_beat.sv
// Per-beat 4-state population count: ones, zeros and x/z bits of one vector.
module countbits_beat #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           in_data,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  output logic [$clog2(WIDTH+1)-1:0] zeros,
  output logic [$clog2(WIDTH+1)-1:0] unknown
);

  localparam int CW = $clog2(WIDTH+1);

  assign ones    = CW'($countbits(in_data, 1'b1));
  assign zeros   = CW'($countbits(in_data, 1'b0));
  assign unknown = CW'(WIDTH) - ones - zeros;

endmodule

// File: rtl/countbits_frame_accum.sv
// Accumulates per-beat bit counts over an in_last-delimited frame and
// presents one saturating summary per frame on a valid/ready output.
module countbits_frame_accum
  import countbits_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = CB_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_ones,
  output logic [ACC_W-1:0] out_zeros,
  output logic [ACC_W-1:0] out_unknown,
  output logic [ACC_W-1:0] out_beats,
  output logic             out_sat
);

  localparam int CW = $clog2(WIDTH+1);

  cb_state_t        state, state_nxt;
  logic [CW-1:0]    b_ones, b_zeros, b_unk;
  logic [ACC_W-1:0] acc_ones, acc_zeros, acc_unk, acc_beats;
  logic             acc_sat;
  sat_res_t         s_ones, s_zeros, s_unk, s_beats;
  logic             accept, sum_sat;
  logic             unused_hi;

  countbits_beat #(.WIDTH(WIDTH)) u_beat (
    .in_data (in_data),
    .ones    (b_ones),
    .zeros   (b_zeros),
    .unknown (b_unk)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    s_ones  = sat_add(CB_MAX_W'(acc_ones),  CB_MAX_W'(b_ones),  ACC_W);
    s_zeros = sat_add(CB_MAX_W'(acc_zeros), CB_MAX_W'(b_zeros), ACC_W);
    s_unk   = sat_add(CB_MAX_W'(acc_unk),   CB_MAX_W'(b_unk),   ACC_W);
    s_beats = sat_add(CB_MAX_W'(acc_beats), CB_MAX_W'(1),       ACC_W);
  end

  assign sum_sat = s_ones.carry | s_zeros.carry | s_unk.carry | s_beats.carry;

  // Clamped sums never exceed ACC_W bits; the upper bits are always zero.
  assign unused_hi = ^{s_ones.val, s_zeros.val, s_unk.val, s_beats.val};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACCUM;
      default:                        state_nxt = ACCUM;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == ACCUM) && !rst;
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_ones    <= '0;
      acc_zeros   <= '0;
      acc_unk     <= '0;
      acc_beats   <= '0;
      acc_sat     <= 1'b0;
      out_ones    <= '0;
      out_zeros   <= '0;
      out_unknown <= '0;
      out_beats   <= '0;
      out_sat     <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        // Summary includes the last beat; accumulators restart for next frame.
        out_ones    <= s_ones.val[ACC_W-1:0];
        out_zeros   <= s_zeros.val[ACC_W-1:0];
        out_unknown <= s_unk.val[ACC_W-1:0];
        out_beats   <= s_beats.val[ACC_W-1:0];
        out_sat     <= acc_sat | sum_sat;
        acc_ones    <= '0;
        acc_zeros   <= '0;
        acc_unk     <= '0;
        acc_beats   <= '0;
        acc_sat     <= 1'b0;
      end else begin
        acc_ones    <= s_ones.val[ACC_W-1:0];
        acc_zeros   <= s_zeros.val[ACC_W-1:0];
        acc_unk     <= s_unk.val[ACC_W-1:0];
        acc_beats   <= s_beats.val[ACC_W-1:0];
        acc_sat     <= acc_sat | sum_sat;
      end
    end
  end

endmodule

// File: tb/tb_countbits_frame_accum.sv
// Randomized bench for countbits_frame_accum: ACC_W=16 and ACC_W=4 instances
// share one stimulus stream and are checked against a frame-level model.
module tb_countbits_frame_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;

  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_ones, out_zeros, out_unknown, out_beats;
  logic        in_ready4, out_valid4, out_sat4;
  logic [3:0]  out_ones4, out_zeros4, out_unknown4, out_beats4;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] frame_q[$];

  always #5 clk = ~clk;

  countbits_frame_accum #(.WIDTH(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ones(out_ones), .out_zeros(out_zeros), .out_unknown(out_unknown),
    .out_beats(out_beats), .out_sat(out_sat)
  );

  countbits_frame_accum #(.WIDTH(8), .ACC_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_ones(out_ones4), .out_zeros(out_zeros4), .out_unknown(out_unknown4),
    .out_beats(out_beats4), .out_sat(out_sat4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Model: frame totals from the accepted beats, then clamp per accumulator width.
  task automatic check_vals(input string tag);
    int o = 0, z = 0, u = 0, b;
    foreach (frame_q[i])
      for (int k = 0; k < 8; k++)
        if (frame_q[i][k] === 1'b1)      o++;
        else if (frame_q[i][k] === 1'b0) z++;
        else                             u++;
    b = frame_q.size();
    chk({tag, ".vld16"},  32'(out_valid),   32'd1);
    chk({tag, ".rdy16"},  32'(in_ready),    32'd0);
    chk({tag, ".ones16"}, 32'(out_ones),    32'(clamp(o, 65535)));
    chk({tag, ".zero16"}, 32'(out_zeros),   32'(clamp(z, 65535)));
    chk({tag, ".unk16"},  32'(out_unknown), 32'(clamp(u, 65535)));
    chk({tag, ".beat16"}, 32'(out_beats),   32'(clamp(b, 65535)));
    chk({tag, ".sat16"},  32'(out_sat),     32'((o > 65535) || (z > 65535) || (u > 65535) || (b > 65535)));
    chk({tag, ".vld4"},   32'(out_valid4),  32'd1);
    chk({tag, ".rdy4"},   32'(in_ready4),   32'd0);
    chk({tag, ".ones4"},  32'(out_ones4),   32'(clamp(o, 15)));
    chk({tag, ".zero4"},  32'(out_zeros4),  32'(clamp(z, 15)));
    chk({tag, ".unk4"},   32'(out_unknown4), 32'(clamp(u, 15)));
    chk({tag, ".beat4"},  32'(out_beats4),  32'(clamp(b, 15)));
    chk({tag, ".sat4"},   32'(out_sat4),    32'((o > 15) || (z > 15) || (u > 15) || (b > 15)));
  endtask

  // Offer one beat (after random idle gaps) and wait until it is accepted.
  task automatic put_beat(input logic [7:0] d, input logic last);
    int n = 0;
    @(posedge clk); #1;
    while ($urandom_range(3) == 0) begin
      in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_tmo", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    frame_q.push_back(d);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
  endtask

  // Called right after the last beat's accepting edge.
  task automatic check_frame(input string tag, input int hold);
    @(negedge clk);
    check_vals({tag, ".n1"});
    if (hold > 0) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_vals({tag, ".hold"});
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".vld_drop"},  32'(out_valid),  32'd0);
    chk({tag, ".vld_drop4"}, 32'(out_valid4), 32'd0);
    chk({tag, ".rdy_back"},  32'(in_ready),   32'd1);
    chk({tag, ".rdy_back4"}, 32'(in_ready4),  32'd1);
    frame_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] xz0, xz1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy",  32'(in_ready),  32'd0);
    chk("rst.vld",  32'(out_valid), 32'd0);
    chk("rst.ones", 32'(out_ones),  32'd0);
    chk("rst.beat", 32'(out_beats), 32'd0);
    chk("rst.sat",  32'(out_sat),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy_after", 32'(in_ready), 32'd1);

    put_beat(8'hF0, 1'b1); check_frame("single", 0);

    put_beat(8'hFF, 1'b0); put_beat(8'h00, 1'b0); put_beat(8'h0F, 1'b1);
    check_frame("three", 1);

    xz0 = 8'bxz10_xz10; xz1 = 8'bzzzz_1111;
    put_beat(xz0, 1'b0); put_beat(xz1, 1'b1);
    check_frame("xz", 0);

    put_beat(8'h33, 1'b0); put_beat(8'h81, 1'b1);
    check_frame("hold5", 5);
    put_beat(8'h07, 1'b1); check_frame("after_hold", 0);

    put_beat(8'hFF, 1'b0); put_beat(8'hFF, 1'b0); put_beat(8'hFF, 1'b1);
    check_frame("sat", 0);
    put_beat(8'h01, 1'b1); check_frame("clean", 0);

    // Reset mid-frame discards the partial frame.
    put_beat(8'hAA, 1'b0); put_beat(8'h55, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst.vld", 32'(out_valid), 32'd0);
    chk("midrst.rdy", 32'(in_ready),  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst.vld_after", 32'(out_valid), 32'd0);
    frame_q.delete();
    put_beat(8'h01, 1'b1); check_frame("post_midrst", 0);

    // Reset during HOLD discards the pending summary.
    put_beat(8'hFF, 1'b1);
    @(negedge clk);
    chk("holdrst.vld_pre", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("holdrst.vld",  32'(out_valid),  32'd0);
    chk("holdrst.vld4", 32'(out_valid4), 32'd0);
    chk("holdrst.ones", 32'(out_ones),   32'd0);
    frame_q.delete();

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) put_beat(8'($urandom), 1'(i == len - 1));
      check_frame("rand", $urandom_range(3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
